avalon_obi_responder: RTL

Avalon-MM pipelined slave that forwards each accepted transfer to an OBI-style host port (req/gnt/rvalid), the same handshake the core presents. Used wherever a Qsys master must reach a core-side OBI responder, e.g. the debug-module memory or a tightly coupled RAM. Responses return in order as Avalon readdatavalid or writeresponsevalid. Outstanding transfers are tracked in a small FIFO that records the operation type of each transfer.

---
 rtl/avalon_obi_responder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/avalon_obi_responder.sv
// avalon_obi_responder
// ---------------------------------------------------------------------------
// Avalon-MM pipelined slave that forwards every accepted transfer to an
// OBI-style host port (req/gnt/rvalid) and returns the OBI responses in order
// as Avalon readdatavalid / writeresponsevalid strobes.
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   avs_*                    Avalon-MM slave side (address, read, write,
//                            byteenable, writedata, waitrequest, readdata,
//                            readdatavalid, response, writeresponsevalid)
//   obi_req_o / obi_gnt_i    OBI address-phase handshake
//   obi_we_o, obi_be_o,
//   obi_addr_o, obi_wdata_o  OBI request payload (passed straight through)
//   obi_rvalid_i, obi_rdata_i,
//   obi_err_i                OBI response phase
//   protocol_err_o           sticky: an rvalid arrived with nothing outstanding
// ---------------------------------------------------------------------------
module avalon_obi_responder #(
   parameter int AddrWidth      = 32,
   parameter int MaxOutstanding = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [AddrWidth-1:0] avs_address,
   input  logic                 avs_read,
   input  logic                 avs_write,
   input  logic [3:0]           avs_byteenable,
   input  logic [31:0]          avs_writedata,
   output logic                 avs_waitrequest,
   output logic [31:0]          avs_readdata,
   output logic                 avs_readdatavalid,
   output logic [1:0]           avs_response,
   output logic                 avs_writeresponsevalid,
   output logic                 obi_req_o,
   input  logic                 obi_gnt_i,
   output logic                 obi_we_o,
   output logic [3:0]           obi_be_o,
   output logic [AddrWidth-1:0] obi_addr_o,
   output logic [31:0]          obi_wdata_o,
   input  logic                 obi_rvalid_i,
   input  logic [31:0]          obi_rdata_i,
   input  logic                 obi_err_i,
   output logic                 protocol_err_o
);

   localparam int CntW = $clog2(MaxOutstanding + 1);

   logic [CntW-1:0]           count_q, count_d;
   // Op FIFO held as a shift register: bit 0 is the oldest transfer,
   // bit (count-1) the newest. 1 = write, 0 = read.
   logic [MaxOutstanding-1:0] ops_q, ops_d;
   logic                      rdv_q, wrv_q, perr_q;
   logic [31:0]               rdata_q;
   logic [1:0]                resp_q;

   logic            req_v, room, accept, pop;
   logic [CntW-1:0] push_idx;

   // ---------------- request path ----------------
   assign req_v  = avs_read | avs_write;
   // A response arriving this cycle frees a slot that can be refilled at once.
   assign room   = (count_q < CntW'(MaxOutstanding)) | obi_rvalid_i;
   assign obi_req_o       = req_v & room;
   assign obi_we_o        = avs_write;
   assign obi_be_o        = avs_byteenable;
   assign obi_addr_o      = avs_address;
   assign obi_wdata_o     = avs_writedata;
   assign avs_waitrequest = req_v & ~(obi_req_o & obi_gnt_i);

   assign accept = obi_req_o & obi_gnt_i;
   assign pop    = obi_rvalid_i & (count_q != '0);

   // When popping in the same cycle the whole FIFO shifts down by one, so the
   // new entry lands one slot lower than the current fill level.
   assign push_idx = count_q - CntW'(pop);

   for (genvar gi = 0; gi < MaxOutstanding; gi++) begin : g_ops
      logic shifted;
      if (gi == MaxOutstanding - 1) begin : g_top
         assign shifted = pop ? 1'b0 : ops_q[gi];
      end else begin : g_mid
         assign shifted = pop ? ops_q[gi+1] : ops_q[gi];
      end
      assign ops_d[gi] = (accept && (push_idx == CntW'(gi))) ? avs_write : shifted;
   end

   always_comb begin
      count_d = count_q;
      case ({accept, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   // ---------------- response path ----------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
         ops_q   <= '0;
         rdv_q   <= 1'b0;
         wrv_q   <= 1'b0;
         rdata_q <= '0;
         resp_q  <= 2'b00;
         perr_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         ops_q   <= ops_d;
         rdv_q   <= pop & ~ops_q[0];
         wrv_q   <= pop &  ops_q[0];
         if (pop) begin
            rdata_q <= ops_q[0] ? 32'h0 : obi_rdata_i;
            resp_q  <= obi_err_i ? 2'b10 : 2'b00;
         end
         // rvalid with nothing outstanding (including a stale one after reset)
         if (obi_rvalid_i && (count_q == '0)) begin
            perr_q <= 1'b1;
         end
      end
   end

   assign avs_readdatavalid      = rdv_q;
   assign avs_writeresponsevalid = wrv_q;
   assign avs_readdata           = rdata_q;
   assign avs_response           = resp_q;
   assign protocol_err_o         = perr_q;

   // The master must never issue read and write together; write wins if it does.
   a_no_rd_wr: assert property (@(posedge clk_i) disable iff (rst_i) !(avs_read && avs_write));

endmodule
